dmem_run_sequencer: RTL and testbench
=====================================

Name: dmem_run_sequencer

Overview:
Owns the single D-memory port and the CPU enable/start controls around the pipelined CPU. After reset the host (bench or loader) has the memory: it preloads data, then requests a run. The block hands the memory port to the CPU, pulses start, and enforces a watchdog cycle limit. It returns the port to the host on halt or timeout so results can be read back.

Parameters:
AW, 8, D-memory address width
DW, 16, D-memory data width
RUN_LIMIT, 200, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
host_req  in  1  host memory request; held high until host_ack
host_we  in  1  1=write, 0=read; sampled with host_req
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_ack  out  1  one-cycle acknowledge of a host request
host_rdata  out  DW  read data; valid in the host_ack cycle, held until the next ack
host_go  in  1  request a CPU run; ignored unless in LOAD or DONE
host_halt  in  1  abort the current run
cpu_addr  in  AW  CPU d_addr
cpu_we  in  1  CPU d_we
cpu_wdata  in  DW  CPU d_dataout
cpu_rdata  out  DW  to CPU d_datain; equals mem_rdata
cpu_enable  out  1  CPU enable
cpu_start  out  1  one-cycle CPU start pulse
mem_addr  out  AW  to D_MEMORY addr
mem_we  out  1  to D_MEMORY d_we
mem_wdata  out  DW  to D_MEMORY datain
mem_rdata  in  DW  from D_MEMORY dataout; combinational read of mem_addr
state  out  2  00=LOAD 01=START 10=RUN 11=DONE
timeout  out  1  set when the last run ended by watchdog; cleared on the next START

Behaviour:
- Reset (rst_n=0 at a clk edge): state=LOAD. cpu_enable=0, cpu_start=0, host_ack=0, host_rdata=0, timeout=0, watchdog count=0. Reset applies mid-run too; the CPU is disabled on the next edge.
- Mux: in LOAD/DONE, mem_addr/mem_we/mem_wdata come from the host, with mem_we = host_req & host_we & ~host_ack. In START/RUN they come from the CPU (mem_we=cpu_we). cpu_rdata always equals mem_rdata.
- Host handshake (LOAD/DONE only):
  - Cycle N: host_req=1 and host_ack=0 -> memory access performed in cycle N.
  - Edge ending N: host_ack<=1 and host_rdata<=mem_rdata (write: host_rdata<=host_wdata).
  - Cycle N+1: host_ack=1 and no new access is started. Back-to-back requests therefore cost 2 cycles each.
  - host_req in START/RUN is held pending (no ack) until DONE.
- LOAD: host_go=1 and no access in flight -> START. If host_go and host_req are both high, the access completes first and host_go is honoured once host_ack=0.
- START (1 cycle): cpu_enable=1, cpu_start=1, timeout<=0, watchdog<=0 -> RUN.
- RUN: cpu_enable=1, cpu_start=0, watchdog increments each cycle.
  - host_halt=1 -> DONE.
  - RUN_LIMIT!=0 and watchdog==RUN_LIMIT-1 -> DONE with timeout<=1.
  - Halt and expiry in the same cycle -> DONE with timeout=1.
- DONE: cpu_enable=0 and the host owns memory. host_go -> START (re-run without reload; CPU state is not reset by this block).
- The watchdog counter is 16 bits and saturates; it never wraps.
- host_go and host_halt are level-sampled. The host must deassert host_go; a held host_go re-triggers from DONE.

Optional Feature:
DMEM_RUN_SEQ_PERF_EN
- Defined: adds outputs perf_cycles[15:0] (RUN cycles of the last run) and perf_wr[15:0] (CPU writes, i.e. cpu_we=1 in RUN cycles). Both are cleared in START, saturate at 16'hFFFF, and hold in DONE/LOAD.
- Undefined: ports absent and no counters synthesised; all other behaviour is identical.

Test Plan:
- Reset, then host writes 16'h1234 to addr 8'h05 and reads it back -> mem_we high for exactly 1 cycle; host_ack on the next cycle; host_rdata=16'h1234. State stays 00 and cpu_enable=0 throughout.
- From LOAD, pulse host_go -> next cycle state=01 with cpu_start=1 for exactly 1 cycle. Following cycle state=10, cpu_enable=1, mem_addr tracks cpu_addr.
- With RUN_LIMIT=200 and no halt -> state=11 exactly 200 cycles after entering RUN; timeout=1, cpu_enable=0.
- In RUN, assert host_req read of 8'h05 -> no host_ack during RUN; after host_halt, ack arrives in the second DONE cycle with the current memory value. The CPU's prior write to 8'h05 (e.g. 16'h00AA) is visible.
- Drop rst_n for one edge mid-RUN -> next cycle state=00, cpu_enable=0, host_ack=0, timeout=0. A new host_go run starts cleanly.
- With DMEM_RUN_SEQ_PERF_EN defined, a run of 50 cycles with 3 CPU writes, halted by the host -> perf_cycles=50, perf_wr=3, held in DONE.

Source files
------------

// File: rtl/dmem_run_sequencer.sv
// dmem_run_sequencer
// Arbitrates the single D-memory port between the host loader and the
// pipelined CPU, launches CPU runs with a one-cycle start pulse and bounds
// each run with a saturating watchdog.
// Optional feature macro: DMEM_RUN_SEQ_PERF_EN adds perf_cycles/perf_wr
// run statistics; when undefined those ports and counters are absent.
module dmem_run_sequencer #(
    parameter int          AW        = 8,
    parameter int          DW        = 16,
    parameter int unsigned RUN_LIMIT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    input  logic          host_go,
    input  logic          host_halt,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_enable,
    output logic          cpu_start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    state,
    output logic          timeout
`ifdef DMEM_RUN_SEQ_PERF_EN
    ,
    output logic [15:0]   perf_cycles,
    output logic [15:0]   perf_wr
`endif
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_START = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Last watchdog value of a run; a limit of 0 means the watchdog never fires.
    localparam logic [15:0] LIMIT_M1 = (RUN_LIMIT == 0) ? 16'd0 : 16'(RUN_LIMIT - 1);

    state_t        r_state;
    logic          r_hostAck;
    logic [DW-1:0] r_hostRdata;
    logic          r_cpuEnable;
    logic          r_cpuStart;
    logic          r_timeout;
    logic [15:0]   r_wdog;

    logic w_hostOwns;
    logic w_hostAccess;
    logic w_goOk;
    logic w_expire;

    // Host owns memory in LOAD/DONE; an access starts only when no ack is showing,
    // and a run is launched only once no host access is in progress.
    always_comb begin
        w_hostOwns   = (r_state == S_LOAD) || (r_state == S_DONE);
        w_hostAccess = w_hostOwns && host_req && !r_hostAck;
        w_goOk       = host_go && !w_hostAccess && !r_hostAck;
        w_expire     = (RUN_LIMIT != 0) && (r_wdog == LIMIT_M1);
    end

    // Memory port mux: host side while it owns the port, CPU side otherwise.
    always_comb begin
        if (w_hostOwns) begin
            mem_addr  = host_addr;
            mem_we    = host_req && host_we && !r_hostAck;
            mem_wdata = host_wdata;
        end else begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign host_ack   = r_hostAck;
    assign host_rdata = r_hostRdata;
    assign cpu_enable = r_cpuEnable;
    assign cpu_start  = r_cpuStart;
    assign state      = r_state;
    assign timeout    = r_timeout;

    // Run sequencer: host handshake, run launch, watchdog and halt handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_hostAck   <= 1'b0;
            r_hostRdata <= '0;
            r_cpuEnable <= 1'b0;
            r_cpuStart  <= 1'b0;
            r_timeout   <= 1'b0;
            r_wdog      <= 16'd0;
        end else begin
            r_hostAck  <= w_hostAccess;
            r_cpuStart <= 1'b0;
            if (w_hostAccess) begin
                r_hostRdata <= host_we ? host_wdata : mem_rdata;
            end
            case (r_state)
                S_LOAD, S_DONE: begin
                    if (w_goOk) begin
                        r_state     <= S_START;
                        r_cpuEnable <= 1'b1;
                        r_cpuStart  <= 1'b1;
                    end else begin
                        r_cpuEnable <= 1'b0;
                    end
                end
                S_START: begin
                    r_timeout   <= 1'b0;
                    r_wdog      <= 16'd0;
                    r_cpuEnable <= 1'b1;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (r_wdog != 16'hFFFF) begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                    if (w_expire) begin
                        r_state     <= S_DONE;
                        r_timeout   <= 1'b1;
                        r_cpuEnable <= 1'b0;
                    end else if (host_halt) begin
                        r_state     <= S_DONE;
                        r_cpuEnable <= 1'b0;
                    end else begin
                        r_cpuEnable <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_cpuEnable <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_RUN_SEQ_PERF_EN
    logic [15:0] r_perfCycles;
    logic [15:0] r_perfWr;

    // Run statistics: cleared at launch, counted during RUN, saturating, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perfCycles <= 16'd0;
            r_perfWr     <= 16'd0;
        end else if (r_state == S_START) begin
            r_perfCycles <= 16'd0;
            r_perfWr     <= 16'd0;
        end else if (r_state == S_RUN) begin
            if (r_perfCycles != 16'hFFFF) begin
                r_perfCycles <= r_perfCycles + 16'd1;
            end
            if (cpu_we && (r_perfWr != 16'hFFFF)) begin
                r_perfWr <= r_perfWr + 16'd1;
            end
        end
    end

    assign perf_cycles = r_perfCycles;
    assign perf_wr     = r_perfWr;
`endif

endmodule

// File: tb/tb_dmem_run_sequencer.sv
// tb_dmem_run_sequencer
// Self-checking bench: a bench-side D-memory, a transaction-level reference
// model compared every cycle, plus directed literal expectations.
// Build with DMEM_RUN_SEQ_PERF_EN defined to also cover the perf counters.
module tb_dmem_run_sequencer;

    localparam int LIMIT = 200;

    logic        clk;
    logic        rst_n;
    logic        hostReq;
    logic        hostWe;
    logic [7:0]  hostAddr;
    logic [15:0] hostWdata;
    logic        hostAck;
    logic [15:0] hostRdata;
    logic        hostGo;
    logic        hostHalt;
    logic [7:0]  cpuAddr;
    logic        cpuWe;
    logic [15:0] cpuWdata;
    logic [15:0] cpuRdata;
    logic        cpuEnable;
    logic        cpuStart;
    logic [7:0]  memAddr;
    logic        memWe;
    logic [15:0] memWdata;
    logic [15:0] memRdata;
    logic [1:0]  dutState;
    logic        dutTimeout;
`ifdef DMEM_RUN_SEQ_PERF_EN
    logic [15:0] perfCycles;
    logic [15:0] perfWr;
`endif

    int nChecks = 0;
    int nPass   = 0;
    bit checkEn = 1'b0;

    dmem_run_sequencer #(.AW(8), .DW(16), .RUN_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (hostReq),
        .host_we    (hostWe),
        .host_addr  (hostAddr),
        .host_wdata (hostWdata),
        .host_ack   (hostAck),
        .host_rdata (hostRdata),
        .host_go    (hostGo),
        .host_halt  (hostHalt),
        .cpu_addr   (cpuAddr),
        .cpu_we     (cpuWe),
        .cpu_wdata  (cpuWdata),
        .cpu_rdata  (cpuRdata),
        .cpu_enable (cpuEnable),
        .cpu_start  (cpuStart),
        .mem_addr   (memAddr),
        .mem_we     (memWe),
        .mem_wdata  (memWdata),
        .mem_rdata  (memRdata),
        .state      (dutState),
        .timeout    (dutTimeout)
`ifdef DMEM_RUN_SEQ_PERF_EN
        ,
        .perf_cycles(perfCycles),
        .perf_wr    (perfWr)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench D-memory with combinational read and clocked write.
    logic [15:0] benchMem [256];
    initial for (int i = 0; i < 256; i++) benchMem[i] = 16'd0;
    assign memRdata = benchMem[memAddr];
    always @(posedge clk) if (memWe) benchMem[memAddr] <= memWdata;

    // Reference model: phase, pending-ack flag, elapsed run cycles, private memory image.
    logic [1:0]  mState;
    bit          mAck;
    logic [15:0] mRdata;
    bit          mTimeout;
    int          mRunCycles;
    int          mPerfWr;
    logic [15:0] mMem [256];
    initial begin
        for (int i = 0; i < 256; i++) mMem[i] = 16'd0;
        mState = 2'd0; mAck = 0; mRdata = 16'd0; mTimeout = 0; mRunCycles = 0; mPerfWr = 0;
    end

    // Advance the model by one clock using the rules of the run protocol.
    always @(posedge clk) begin
        bit hostSide;
        bit access;
        hostSide = (mState == 2'd0) || (mState == 2'd3);
        access   = hostSide && hostReq && !mAck;
        if (!rst_n) begin
            mState = 2'd0; mAck = 0; mRdata = 16'd0; mTimeout = 0; mRunCycles = 0; mPerfWr = 0;
        end else begin
            if (access) begin
                if (hostWe) begin
                    mMem[hostAddr] = hostWdata;
                    mRdata = hostWdata;
                end else begin
                    mRdata = mMem[hostAddr];
                end
            end else if (!hostSide && cpuWe) begin
                mMem[cpuAddr] = cpuWdata;
            end
            case (mState)
                2'd1: begin
                    mTimeout = 0; mRunCycles = 0; mPerfWr = 0; mState = 2'd2;
                end
                2'd2: begin
                    mRunCycles = mRunCycles + 1;
                    if (cpuWe) mPerfWr = mPerfWr + 1;
                    if (mRunCycles == LIMIT) begin
                        mTimeout = 1; mState = 2'd3;
                    end else if (hostHalt) begin
                        mState = 2'd3;
                    end
                end
                default: begin
                    if (hostGo && !access && !mAck) mState = 2'd1;
                end
            endcase
            mAck = access;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            bit hostSide;
            hostSide = (mState == 2'd0) || (mState == 2'd3);
            checkOutput("state", 32'(dutState), 32'(mState));
            checkOutput("cpu_enable", 32'(cpuEnable), 32'(mState == 2'd1 || mState == 2'd2));
            checkOutput("cpu_start", 32'(cpuStart), 32'(mState == 2'd1));
            checkOutput("host_ack", 32'(hostAck), 32'(mAck));
            checkOutput("host_rdata", 32'(hostRdata), 32'(mRdata));
            checkOutput("timeout", 32'(dutTimeout), 32'(mTimeout));
            checkOutput("mem_we", 32'(memWe), 32'(hostSide ? (hostReq && hostWe && !mAck) : cpuWe));
            checkOutput("mem_addr", 32'(memAddr), 32'(hostSide ? hostAddr : cpuAddr));
            checkOutput("mem_wdata", 32'(memWdata), 32'(hostSide ? hostWdata : cpuWdata));
            checkOutput("cpu_rdata", 32'(cpuRdata), 32'(mMem[memAddr]));
`ifdef DMEM_RUN_SEQ_PERF_EN
            checkOutput("perf_cycles", 32'(perfCycles), 32'(mRunCycles));
            checkOutput("perf_wr", 32'(perfWr), 32'(mPerfWr));
`endif
        end
    end

    task automatic applyStimulus(input logic req, input logic we, input logic [7:0] addr,
                                 input logic [15:0] wdata, input logic go, input logic halt,
                                 input logic cWe, input logic [7:0] cAddr, input logic [15:0] cWdata);
        hostReq = req; hostWe = we; hostAddr = addr; hostWdata = wdata;
        hostGo = go; hostHalt = halt; cpuWe = cWe; cpuAddr = cAddr; cpuWdata = cWdata;
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(2);
        checkEn = 1'b1;
        checkOutput("reset state", 32'(dutState), 32'h0);
        checkOutput("reset host_ack", 32'(hostAck), 32'h0);
        checkOutput("reset cpu_enable", 32'(cpuEnable), 32'h0);
        rst_n = 1'b1;

        // Host write 1234 to 05, then read it back.
        applyStimulus(1, 1, 8'h05, 16'h1234, 0, 0, 0, 8'h00, 16'h0000);
        #1;
        checkOutput("write mem_we", 32'(memWe), 32'h1);
        stepCycles(1);
        checkOutput("write ack", 32'(hostAck), 32'h1);
        checkOutput("write ack cycle mem_we", 32'(memWe), 32'h0);
        applyStimulus(0, 0, 8'h05, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        applyStimulus(1, 0, 8'h05, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        checkOutput("readback ack", 32'(hostAck), 32'h1);
        checkOutput("readback data", 32'(hostRdata), 32'h1234);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);

        // Launch a run, CPU writes 00AA to 05, host read held pending until halt.
        applyStimulus(0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        checkOutput("start state", 32'(dutState), 32'h1);
        checkOutput("start pulse", 32'(cpuStart), 32'h1);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h33, 16'h0000);
        stepCycles(1);
        checkOutput("run state", 32'(dutState), 32'h2);
        checkOutput("run start low", 32'(cpuStart), 32'h0);
        checkOutput("run mem_addr", 32'(memAddr), 32'h33);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 1, 8'h05, 16'h00AA);
        stepCycles(1);
        applyStimulus(1, 0, 8'h05, 16'h0000, 0, 0, 0, 8'h05, 16'h0000);
        stepCycles(5);
        checkOutput("pending no ack", 32'(hostAck), 32'h0);
        applyStimulus(1, 0, 8'h05, 16'h0000, 0, 1, 0, 8'h05, 16'h0000);
        stepCycles(1);
        checkOutput("halt state", 32'(dutState), 32'h3);
        checkOutput("halt cpu_enable", 32'(cpuEnable), 32'h0);
        checkOutput("halt no ack yet", 32'(hostAck), 32'h0);
        applyStimulus(1, 0, 8'h05, 16'h0000, 0, 0, 0, 8'h05, 16'h0000);
        stepCycles(1);
        checkOutput("done ack", 32'(hostAck), 32'h1);
        checkOutput("done read 00AA", 32'(hostRdata), 32'h00AA);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);

        // Re-run from DONE with no halt: watchdog expiry.
        applyStimulus(0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        cnt = 0;
        while (dutState != 2'b11 && cnt < 400) begin
            stepCycles(1);
            cnt++;
        end
        checkOutput("watchdog run length", 32'(cnt), 32'd200);
        checkOutput("watchdog timeout", 32'(dutTimeout), 32'h1);
        checkOutput("watchdog cpu_enable", 32'(cpuEnable), 32'h0);

        // Reset in the middle of a run.
        applyStimulus(0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(10);
        rst_n = 1'b0;
        stepCycles(1);
        rst_n = 1'b1;
        checkOutput("midrun reset state", 32'(dutState), 32'h0);
        checkOutput("midrun reset cpu_enable", 32'(cpuEnable), 32'h0);
        checkOutput("midrun reset timeout", 32'(dutTimeout), 32'h0);
        applyStimulus(0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        checkOutput("restart state", 32'(dutState), 32'h1);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        checkOutput("restart run", 32'(dutState), 32'h2);

        // 50-cycle run with 3 CPU writes, halted by the host on the last cycle.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(0, 0, 8'h00, 16'h0000, 0, (i == 49),
                          (i == 3 || i == 10 || i == 20), 8'(8'h40 + i), 16'(i));
            stepCycles(1);
        end
        checkOutput("perf run done", 32'(dutState), 32'h3);
        checkOutput("perf run no timeout", 32'(dutTimeout), 32'h0);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(3);
`ifdef DMEM_RUN_SEQ_PERF_EN
        checkOutput("perf_cycles held", 32'(perfCycles), 32'd50);
        checkOutput("perf_wr held", 32'(perfWr), 32'd3);
`endif
        applyStimulus(1, 0, 8'h43, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(1);
        checkOutput("cpu write visible", 32'(hostRdata), 32'h0003);
        applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000);
        stepCycles(2);

        checkEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
